// File: rtl/updown_counter_pkg.sv
// Shared constants and load clamping for the up/down modulo counter.
package updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned MAX_WIDTH = 32;

  // Limit a load value to the legal count range 0..max.
  function automatic logic [MAX_WIDTH-1:0] clamp_load(input logic [MAX_WIDTH-1:0] value,
                                                     input logic [MAX_WIDTH-1:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// Enable divider: asserts tick on every PRESCALE-th en-high cycle; clr restarts the phase.
module updown_counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign tick = en && (phase_q == LAST);

  // en=0 freezes the phase; clr wins over counting.
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == LAST) ? '0 : PW'(phase_q + PW'(1));
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, enable and per-cycle wrap/saturate selection; updates on falling clk.
// Optional enable prescaler is built when UPDOWN_COUNTER_PRESCALE_EN is defined.
module updown_mod_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int unsigned     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap
);

  logic             step_en;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   max_ext;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic tick;

  updown_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign step_en = en && tick;
`else
  // PRESCALE only matters when the prescaler is built.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step_en         = en;
`endif

  assign cnt_ext  = {1'b0, count};
  assign max_ext  = {1'b0, MAX_VAL};
  assign at_limit = ((up_dn == DIR_UP) && (count == MAX_VAL)) ||
                    ((up_dn == DIR_DOWN) && (count == '0));

  // Next value computed one bit wider so a reduced MAX_VAL never wraps modulo 2**WIDTH.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = WIDTH'(clamp_load(MAX_WIDTH'(load_val), MAX_WIDTH'(MAX_VAL)));
    end else if (step_en) begin
      if (up_dn == DIR_UP) begin
        if (cnt_ext < max_ext) begin
          count_d = WIDTH'(cnt_ext + (WIDTH+1)'(1));
        end else if (sat == MODE_WRAP) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (cnt_ext != '0) begin
          count_d = WIDTH'(cnt_ext - (WIDTH+1)'(1));
        end else if (sat == MODE_WRAP) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MAX_VAL=9, PRESCALE=3).
module tb_updown_mod_counter;
  import updown_counter_pkg::*;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXV = 9;
  localparam int unsigned PS   = 3;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up_dn;
  logic         sat;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         at_limit;
  logic         wrap;

  int checks   = 0;
  int failures = 0;

  int unsigned m;
  bit          mw;
  int unsigned ps;

  updown_mod_counter #(
    .WIDTH   (W),
    .MAX_VAL (4'd9),
    .PRESCALE(PS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .at_limit(at_limit),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_limit();
    return up_dn ? (m == MAXV) : (m == 0);
  endfunction

  // Advance one falling edge, update the reference model, then settle.
  task automatic step();
    bit eff;
    @(negedge clk);
    if (!reset) begin
      m = 0; mw = 0; ps = 0;
    end else begin
      eff = en;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      eff = en && (ps == PS - 1);
`endif
      mw = 0;
      if (load) begin
        m  = clamp_load(32'(load_val), 32'(MAXV));
        ps = 0;
      end else begin
        if (en) ps = (ps + 1) % PS;
        if (eff) begin
          if (sat) begin
            if (up_dn) m = (m + 1 > MAXV) ? MAXV : m + 1;
            else       m = (m == 0) ? 0 : m - 1;
          end else begin
            mw = up_dn ? (m == MAXV) : (m == 0);
            m  = up_dn ? (m + 1) % (MAXV + 1) : (m + MAXV) % (MAXV + 1);
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 0; en = 0; up_dn = 0; sat = 0; load = 0; load_val = '0;
    m = 0; mw = 0; ps = 0;
    step(); step();
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      failures++; $display("FAIL reset_state count=%0d wrap=%0b required count=0 wrap=0", count, wrap);
    end
    checks++;
    if (at_limit !== 1'b1) begin
      failures++; $display("FAIL reset_at_limit at_limit=%0b required 1", at_limit);
    end
    reset = 1;
  endtask

  task automatic test_count_up_wrap();
    en = 1; up_dn = 1; sat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (32'(count) !== (i % 10) || wrap !== (i == 10)) begin
        failures++;
        $display("FAIL up_wrap step=%0d count=%0d wrap=%0b required count=%0d wrap=%0b",
                 i, count, wrap, i % 10, (i == 10));
      end
    end
  endtask

  task automatic test_saturate();
    en = 0; load = 1; load_val = 4'd7;
    step();
    load = 0; en = 1; sat = 1; up_dn = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (32'(count) !== m || wrap !== 1'b0) begin
        failures++;
        $display("FAIL sat_up step=%0d count=%0d wrap=%0b required count=%0d wrap=0", i, count, wrap, m);
      end
    end
    checks++;
    if (count !== 4'd9 || at_limit !== 1'b1) begin
      failures++; $display("FAIL sat_up_limit count=%0d at_limit=%0b required 9 1", count, at_limit);
    end
    up_dn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (32'(count) !== m || wrap !== 1'b0) begin
        failures++;
        $display("FAIL sat_down step=%0d count=%0d wrap=%0b required count=%0d wrap=0", i, count, wrap, m);
      end
    end
  endtask

  task automatic test_down_wrap_clamp();
    en = 0; load = 1; load_val = 4'd12;
    step();
    checks++;
    if (count !== 4'd9) begin
      failures++; $display("FAIL load_clamp count=%0d required 9", count);
    end
    load_val = 4'd0;
    step();
    load = 0; en = 1; up_dn = 0; sat = 0;
    step();
    checks++;
    if (count !== 4'd9 || wrap !== 1'b1 || 32'(count) !== m) begin
      failures++; $display("FAIL down_wrap count=%0d wrap=%0b required count=9 wrap=1", count, wrap);
    end
    step();
    checks++;
    if (32'(count) !== m || wrap !== 1'b0) begin
      failures++; $display("FAIL down_wrap_after count=%0d wrap=%0b required count=%0d wrap=0", count, wrap, m);
    end
  endtask

  task automatic test_load_priority();
    en = 1; up_dn = 1; sat = 0; load = 1; load_val = 4'd3;
    step();
    checks++;
    if (count !== 4'd3) begin
      failures++; $display("FAIL load_priority count=%0d required 3", count);
    end
    load = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd3 || wrap !== 1'b0) begin
        failures++; $display("FAIL hold step=%0d count=%0d wrap=%0b required count=3 wrap=0", i, count, wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    en = 0; load = 1; load_val = 4'd6;
    step();
    load = 0;
    checks++;
    if (count !== 4'd6) begin
      failures++; $display("FAIL pre_reset count=%0d required 6", count);
    end
    @(posedge clk);
    #2 reset = 0;
    #1;
    m = 0; mw = 0; ps = 0;
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      failures++; $display("FAIL async_reset count=%0d wrap=%0b required count=0 wrap=0", count, wrap);
    end
    load = 1; load_val = 4'd5;
    step();
    checks++;
    if (count !== 4'd0) begin
      failures++; $display("FAIL reset_over_load count=%0d required 0", count);
    end
    reset = 1; load = 0; en = 1; up_dn = 1; sat = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (32'(count) !== m || wrap !== mw) begin
        failures++;
        $display("FAIL resume step=%0d count=%0d wrap=%0b required count=%0d wrap=%0b", i, count, wrap, m, mw);
      end
    end
  endtask

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    en = 0; load = 1; load_val = 4'd0;
    step();
    load = 0; en = 1; up_dn = 1; sat = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (32'(count) !== (i / 3)) begin
        failures++; $display("FAIL prescale cycle=%0d count=%0d required %0d", i, count, i / 3);
      end
    end
    step(); step();
    load = 1; load_val = 4'd5;
    step();
    load = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (32'(count) !== ((i == 3) ? 6 : 5)) begin
        failures++; $display("FAIL prescale_reload cycle=%0d count=%0d required %0d", i, count, (i == 3) ? 6 : 5);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(7) == 0);
      load_val = W'($urandom_range(15));
      en       = ($urandom_range(3) != 0);
      up_dn    = 1'($urandom_range(1));
      sat      = ($urandom_range(3) == 0);
      step();
      checks++;
      if (32'(count) !== m || wrap !== mw || at_limit !== exp_limit()) begin
        failures++;
        $display("FAIL random step=%0d count=%0d wrap=%0b at_limit=%0b required count=%0d wrap=%0b at_limit=%0b",
                 i, count, wrap, at_limit, m, mw, exp_limit());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up_wrap();
    test_saturate();
    test_down_wrap_clamp();
    test_load_priority();
    test_async_reset();
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
